// File: rtl/demux_stream_ctrl.sv
// demux_stream_ctrl: routes one valid/ready source to one of four valid/ready sinks through a one-entry holding register.
// Latency: a word accepted at edge N is presented after edge N and can be delivered at edge N+1; peak rate 1 word/cycle.
// Backpressure: while holding, in_ready follows the addressed sink's out_ready; a stalled sink blocks all traffic (head-of-line).
// Optional feature: define DEMUX_RR_EN to route by an internal round-robin pointer instead of in_dest.
module demux_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [1:0]           in_dest,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [1:0]           sel,
  output logic                 busy,
  output logic [4*CNT_W-1:0]   cnt_flat
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        sel_q;
  logic [1:0]        dest;
  logic [3:0]        vld_q, vld_nxt;
  logic              accept, deliver;

  // A delivery can only happen to the channel the holding register addresses.
  assign deliver  = (state == HOLD) & out_ready[sel_q];
  // Empty register always accepts; a full one accepts only when it drains this same cycle.
  assign in_ready = ~rst & ((state == IDLE) | out_ready[sel_q]);
  assign accept   = in_valid & in_ready;

`ifdef DEMUX_RR_EN
  logic [1:0] rr_ptr;
  logic       unused_dest;

  assign unused_dest = ^in_dest;
  assign dest        = rr_ptr;

  // Round-robin pointer advances once per accepted word, independent of sink readiness.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= 2'd0;
    else if (accept) rr_ptr <= rr_ptr + 2'd1;
  end
`else
  assign dest = in_dest;
`endif

  // Next-state and next out_valid: a new word replaces the old one, a drain without refill empties.
  always_comb begin
    state_nxt = state;
    vld_nxt   = vld_q;
    case (state)
      IDLE: if (accept) state_nxt = HOLD;
      HOLD: if (deliver && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (accept)       vld_nxt = 4'b0001 << dest;
    else if (deliver) vld_nxt = 4'b0000;
  end

  // Holding register and state; data/sel only change on accept so they stay stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      vld_q  <= 4'b0000;
      data_q <= '0;
      sel_q  <= 2'd0;
    end else begin
      state <= state_nxt;
      vld_q <= vld_nxt;
      if (accept) begin
        data_q <= in_data;
        sel_q  <= dest;
      end
    end
  end

  // Per-channel delivery counters, free-running wrap.
  for (genvar g = 0; g < 4; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (deliver && (sel_q == 2'(g))) cnt <= cnt + CNT_W'(1);
    end
    assign cnt_flat[g*CNT_W +: CNT_W] = cnt;
  end

  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign sel       = sel_q;
  assign busy      = (state == HOLD);

endmodule

// File: tb/tb_demux_stream_ctrl.sv
// Bench for demux_stream_ctrl: directed stimulus with a scoreboard of expected deliveries.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
// A monitor pops the scoreboard on every pending delivery and compares channel and data.
module tb_demux_stream_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_dest;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [1:0]        sel;
  logic              busy;
  logic [4*CNT_W-1:0] cnt_flat;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  demux_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel), .busy(busy), .cnt_flat(cnt_flat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Called with inputs aligned #1 after a rising edge.
  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick(n);
    sb.delete();
    rst = 1'b0;
  endtask

  // Offers one word and returns #1 after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic [1:0] dst, input logic [1:0] ech, output int waits);
    bit ok;
    in_data  = d;
    in_dest  = dst;
    in_valid = 1'b1;
    waits    = 0;
    ok       = 1'b0;
    while (!ok) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
      end else begin
        waits++;
        if (waits > 1000) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: data 0x%0h not accepted, waited %0d cycles, expected acceptance", d, waits);
          in_valid = 1'b0;
          return;
        end
      end
    end
    sb.push_back('{data: d, ch: ech});
    @(posedge clk);
    #1;
  endtask

  // Monitor: each pending delivery must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid != 4'b0000 && out_valid != (4'b0001 << sel)) begin
          checks++;
          errors++;
          $display("FAIL onehot: out_valid=%b sel=%0d, expected zero or one-hot at sel", out_valid, sel);
        end
        if ((out_valid & out_ready) != 4'b0000) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_delivery: out_valid=%b data=0x%0h, expected no delivery", out_valid, out_data);
          end else begin
            e = sb.pop_front();
            if (out_data !== e.data || sel !== e.ch || out_valid !== (4'b0001 << e.ch)) begin
              errors++;
              $display("FAIL delivery: got ch=%0d valid=%b data=0x%0h, expected ch=%0d data=0x%0h",
                       sel, out_valid, out_data, e.ch, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dest   = 2'd0;
    out_ready = 4'b1111;

    // Reset values, with sinks ready and reset asserted for two cycles
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_out_data",  out_data,  0);
    check("rst_sel",       sel,       0);
    check("rst_cnt",       cnt_flat,  0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

`ifndef DEMUX_RR_EN
    // Single word to channel 2
    send(8'hA5, 2'd2, 2'd2, w);
    idle();
    @(negedge clk);
    check("single_valid", out_valid, 32'h4);
    check("single_data",  out_data,  32'hA5);
    check("single_busy",  busy,      1);
    tick(1);
    @(negedge clk);
    check("single_one_cycle", out_valid, 0);
    tick(2);
    check("single_cnt", cnt_flat, 32'h0001_0000);
    check("single_sb_empty", sb.size(), 0);

    // Back-to-back stream 0,1,2,3,0,1,2,3 with every sink ready
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i), 2'(i % 4), 2'(i % 4), w);
      check("b2b_no_wait", w, 0);
    end
    idle();
    tick(3);
    check("b2b_cnt", cnt_flat, 32'h0202_0202);
    check("b2b_sb_empty", sb.size(), 0);

    // Backpressure on channel 1 for five cycles, then release with the next word waiting
    do_reset(2);
    out_ready = 4'b1101;
    send(8'h11, 2'd1, 2'd1, w);
    in_data  = 8'h22;
    in_dest  = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",    out_valid, 32'h2);
      check("bp_data",     out_data,  32'h11);
      check("bp_sel",      sel,       1);
      check("bp_in_ready", in_ready,  0);
    end
    @(posedge clk);
    #1;
    out_ready = 4'b1111;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    sb.push_back('{data: 8'h22, ch: 2'd0});
    @(posedge clk);
    #1;
    idle();
    tick(3);
    check("bp_cnt", cnt_flat, 32'h0000_0101);
    check("bp_sb_empty", sb.size(), 0);

    // Reset while holding a word on a stalled channel discards it
    do_reset(2);
    out_ready = 4'b0000;
    send(8'h3C, 2'd3, 2'd3, w);
    idle();
    tick(3);
    @(negedge clk);
    check("midhold_valid", out_valid, 32'h8);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midhold_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midhold_rst_valid", out_valid, 0);
    check("midhold_rst_busy",  busy,      0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 4'b1111;
    tick(5);
    check("midhold_cnt", cnt_flat, 0);

    // Counter wrap on channel 3
    do_reset(2);
    for (int i = 0; i < 256; i++) send(8'(i), 2'd3, 2'd3, w);
    idle();
    tick(3);
    check("wrap_256", cnt_flat, 32'h0000_0000);
    send(8'hEE, 2'd3, 2'd3, w);
    idle();
    tick(3);
    check("wrap_257", cnt_flat, 32'h0100_0000);
    check("wrap_sb_empty", sb.size(), 0);
`else
    // Round-robin order regardless of in_dest
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      send(8'h60 + 8'(i), 2'($urandom_range(0, 3)), 2'(i % 4), w);
      check("rr_no_wait", w, 0);
    end
    idle();
    tick(3);
    check("rr_cnt", cnt_flat, 32'h0101_0202);
    check("rr_sb_empty", sb.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream_ctrl.md
# demux_stream_ctrl

Handshaked stream controller that sequences a 1-to-4 demultiplexer: it accepts one word at a time from a single valid/ready source, holds it in a one-entry register, and delivers it to exactly one of four valid/ready sinks. It also drives the demux select. It keeps a per-channel delivery count for status readout. It sits between a single producer and four consumer channels and converts a free-running combinational demux into a flow-controlled, lossless router.

## Interface
- DATA_W, 8, width of the data word
- CNT_W, 8, width of each per-channel delivery counter
- clk  input  1  rising-edge clock, the block's only clock
- rst  input  1  synchronous, active-high reset
- in_data  input  DATA_W  source word
- in_dest  input  2  destination channel for in_data (ignored when DEMUX_RR_EN is defined)
- in_valid  input  1  source word valid
- in_ready  output  1  block can accept a word this cycle
- out_data  output  DATA_W  held word, shared by all four channels
- out_valid  output  4  one-hot (or zero) valid, bit k = channel k
- out_ready  input  4  per-channel sink ready
- sel  output  2  channel currently addressed by the holding register (demux select)
- busy  output  1  holding register occupied
- cnt_flat  output  4*CNT_W  delivery counters, channel k at [k*CNT_W +: CNT_W]

## Operation
- FSM states:
  - IDLE: register empty.
  - HOLD: register full, out_valid[sel]=1.
- Accept = in_valid & in_ready.
- Deliver = out_valid[sel] & out_ready[sel].
- IDLE:
  - in_ready=1.
  - On accept: capture in_data into out_data and the destination into sel, then go to HOLD.
- HOLD:
  - in_ready = out_ready[sel], which is combinational from out_ready.
  - Deliver without accept: go to IDLE; out_valid clears next cycle.
  - Deliver with accept: capture the new word and destination, stay in HOLD. This gives back-to-back throughput of 1 word/cycle.
  - No deliver: out_data and sel hold stable, out_valid[sel] stays 1. A sink never sees data change while valid is high.
- out_valid is only ever zero or one-hot at bit sel. The other three bits are always 0.
- busy = (state == HOLD).
- Counters:
  - Counter k increments by 1 on each deliver to channel k.
  - Counters wrap modulo 2^CNT_W with no saturation and no flag.
- Reset:
  - rst has priority over all other inputs in the same cycle.
  - Reset mid-HOLD discards the held word and it is not delivered.
  - Reset values: state IDLE, out_data 0, sel 0, out_valid 0, busy 0, all counters 0, round-robin pointer 0.
  - in_ready=0 while rst=1 and 1 in the first cycle after rst deasserts.

## Timing
- Latency: a word accepted at edge N is presented on out_data/out_valid after edge N and can be delivered at edge N+1.
- Peak throughput: 1 word/cycle when the addressed sink holds out_ready=1.
- in_ready depends combinationally on out_ready and sel only, never on in_valid.
- sel, out_data, out_valid, busy and cnt_flat are registered outputs.
- A sink stalled forever blocks the block (head-of-line). No timeout, no bypass to other channels.

## Configuration
- Macro: DEMUX_RR_EN.
- Defined:
  - in_dest is ignored.
  - The destination is a 2-bit round-robin pointer, captured into sel on every accept.
  - The pointer increments by 1 per accept (3 wraps to 0), giving strict order 0,1,2,3,0 regardless of which sinks are ready.
- Undefined:
  - The destination is in_dest sampled on accept.
  - No pointer register is built.

## Test plan
- Reset then single word, tag mode: assert rst 2 cycles, release, send in_data=0xA5 with in_dest=2 and out_ready=4'b1111 -> out_valid=4'b0100 and out_data=0xA5 for exactly 1 cycle; cnt ch2=1, others 0; all outputs 0 during reset.
- Back-to-back stream: 8 words with dest 0,1,2,3,0,1,2,3, in_valid held high, all sinks ready -> in_ready stays 1, one delivery per cycle in order, each counter=2.
- Backpressure: dest=1 word with out_ready[1]=0 for 5 cycles -> out_valid=4'b0010, out_data and sel stable, in_ready=0; release -> delivered once, next word accepted in that same cycle.
- Reset mid-HOLD: hold a word for 0x3C on a stalled channel, pulse rst -> out_valid=0, the word is never delivered, the counter stays 0.
- Counter wrap, CNT_W=8: 256 deliveries to channel 3 -> that counter reads 0; 257 deliveries -> it reads 1.
- DEMUX_RR_EN defined: 6 words with random in_dest, all ready -> delivered to channels 0,1,2,3,0,1; sel follows the same sequence.
